melody_player: RTL and testbench

MELODY_PLAYER -- requirements
Module: melody_player

---
 rtl/melody_player.sv | 175 +++++++++++++++++
 tb/tb_melody_player.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// melody_player: plays a fixed 16-entry song ROM on a single speaker output.
//
// Ports:
//   CLK          system clock
//   RESET_N      asynchronous active-low reset
//   PLAY         start request (ignored while BUSY or when STOP is high)
//   STOP         stop request, returns to idle from any state
//   NOTE_CLK     eight note square waves, bit0 = C4 .. bit7 = C5
//   QUARTER_BEAT tempo square wave, every toggle is one beat
//   SPEAKER      registered audio output
//   NOTE_IDX     current song ROM index
//   NOTE_CODE    current note code, 0 = rest, 1..8 selects NOTE_CLK[0..7]
//   BUSY         high while armed or playing
//   DONE         one-cycle pulse when the song ends without looping
module melody_player #(
  parameter int unsigned GAP_CYCLES = 1000000,
  parameter bit          LOOP       = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       PLAY,
  input  logic       STOP,
  input  logic [7:0] NOTE_CLK,
  input  logic       QUARTER_BEAT,
  output logic       SPEAKER,
  output logic [3:0] NOTE_IDX,
  output logic [3:0] NOTE_CODE,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArm, StGap, StSound} state_e;

  // Entry layout: {code[3:0], dur[1:0]}, note length is dur+1 beats.
  function automatic logic [5:0] rom_entry(input logic [3:0] idx);
    logic [5:0] e;
    case (idx)
      4'd0:    e = {4'd1, 2'd0};
      4'd1:    e = {4'd1, 2'd0};
      4'd2:    e = {4'd5, 2'd0};
      4'd3:    e = {4'd5, 2'd0};
      4'd4:    e = {4'd6, 2'd0};
      4'd5:    e = {4'd6, 2'd0};
      4'd6:    e = {4'd5, 2'd1};
      4'd7:    e = {4'd4, 2'd0};
      4'd8:    e = {4'd4, 2'd0};
      4'd9:    e = {4'd3, 2'd0};
      4'd10:   e = {4'd3, 2'd0};
      4'd11:   e = {4'd2, 2'd0};
      4'd12:   e = {4'd2, 2'd0};
      4'd13:   e = {4'd1, 2'd1};
      4'd14:   e = {4'd0, 2'd0};
      4'd15:   e = {4'd8, 2'd3};
      default: e = '0;
    endcase
    return e;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      code_q, code_d;
  logic [2:0]      beats_q, beats_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            qb_q;
  logic            spk_q, spk_d;
  logic            done_q, done_d;

  logic       beat_ev;
  logic       note_end;
  logic [3:0] next_idx;
  logic [5:0] entry0;
  logic [5:0] entry_n;
  logic [3:0] code_sel;

  assign beat_ev  = QUARTER_BEAT ^ qb_q;
  assign note_end = beat_ev && (beats_q == 3'd1);
  assign next_idx = (idx_q == 4'd15) ? 4'd0 : idx_q + 4'd1;
  assign entry0   = rom_entry(4'd0);
  assign entry_n  = rom_entry(next_idx);
  assign code_sel = code_q - 4'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    beats_d = beats_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    spk_d   = 1'b0;

    if (STOP) begin
      state_d = StIdle;
      code_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (PLAY) begin
            state_d = StArm;
            idx_d   = '0;
          end
        end
        StArm: begin
          if (beat_ev) begin
            state_d = StGap;
            code_d  = entry0[5:2];
            beats_d = {1'b0, entry0[1:0]} + 3'd1;
            gap_d   = '0;
          end
        end
        StGap, StSound: begin
          if (state_q == StGap) begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) state_d = StSound;
          end
          // A note end overrides the gap-to-sound step, so a note shorter
          // than the gap stays muted for its whole length.
          if (note_end) begin
            if ((idx_q != 4'd15) || LOOP) begin
              state_d = StGap;
              idx_d   = next_idx;
              code_d  = entry_n[5:2];
              beats_d = {1'b0, entry_n[1:0]} + 3'd1;
              gap_d   = '0;
            end else begin
              state_d = StIdle;
              code_d  = '0;
              done_d  = 1'b1;
            end
          end else if (beat_ev) begin
            beats_d = beats_q - 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Only drive the tone while remaining in SOUND, so a stop or note change
    // silences the speaker on the very next cycle.
    if ((state_q == StSound) && (state_d == StSound) && (code_q != 4'd0)) begin
      spk_d = NOTE_CLK[code_sel[2:0]];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      idx_q   <= '0;
      code_q  <= '0;
      beats_q <= '0;
      gap_q   <= '0;
      qb_q    <= 1'b0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      beats_q <= beats_d;
      gap_q   <= gap_d;
      qb_q    <= QUARTER_BEAT;
      spk_q   <= spk_d;
      done_q  <= done_d;
    end
  end

  assign SPEAKER   = spk_q;
  assign NOTE_IDX  = idx_q;
  assign NOTE_CODE = code_q;
  assign BUSY      = (state_q != StIdle);
  assign DONE      = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: two instances (LOOP=0 and LOOP=1) share stimulus
// and are compared every cycle against a song-position model.
module tb_melody_player;

  localparam int unsigned Gap  = 4;
  localparam int          Half = 20;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       PLAY = 1'b0;
  logic       STOP = 1'b0;
  logic       QUARTER_BEAT = 1'b0;
  logic [7:0] NOTE_CLK = 8'h00;

  logic       spk0, spk1, busy0, busy1, done0, done1;
  logic [3:0] idx0, idx1, code0, code1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int qb_cnt = 0;

  int rom_code[16]  = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 8};
  int rom_beats[16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 1, 4};

  // Model: mode 0 idle, 1 waiting for first beat, 2 playing.
  int m_mode[2], m_idx[2], m_code[2], m_left[2], m_since[2];
  bit m_spk[2], m_done[2];
  bit m_qb_prev;

  always #5 CLK = ~CLK;

  melody_player #(.GAP_CYCLES(Gap), .LOOP(1'b0)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .PLAY(PLAY), .STOP(STOP), .NOTE_CLK(NOTE_CLK),
    .QUARTER_BEAT(QUARTER_BEAT), .SPEAKER(spk0), .NOTE_IDX(idx0), .NOTE_CODE(code0),
    .BUSY(busy0), .DONE(done0)
  );

  melody_player #(.GAP_CYCLES(Gap), .LOOP(1'b1)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .PLAY(PLAY), .STOP(STOP), .NOTE_CLK(NOTE_CLK),
    .QUARTER_BEAT(QUARTER_BEAT), .SPEAKER(spk1), .NOTE_IDX(idx1), .NOTE_CODE(code1),
    .BUSY(busy1), .DONE(done1)
  );

  function automatic logic [10:0] obs_vec(input int k);
    return (k == 0) ? {spk0, idx0, code0, busy0, done0} : {spk1, idx1, code1, busy1, done1};
  endfunction

  function automatic logic [10:0] exp_vec(input int k);
    return {m_spk[k], 4'(m_idx[k]), 4'(m_code[k]), m_mode[k] != 0, m_done[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_idx[k] = 0; m_code[k] = 0; m_left[k] = 0; m_since[k] = 0;
      m_spk[k] = 1'b0; m_done[k] = 1'b0;
    end
    m_qb_prev = 1'b0;
  endtask

  task automatic model_load(input int k, input int i);
    m_idx[k] = i; m_code[k] = rom_code[i]; m_left[k] = rom_beats[i];
    m_since[k] = 0; m_mode[k] = 2;
  endtask

  // Applies the inputs present before the coming clock edge.
  task automatic model_step();
    bit beat;
    bit ending;
    beat = (QUARTER_BEAT != m_qb_prev);
    for (int k = 0; k < 2; k++) begin
      ending = (m_mode[k] == 2) && beat && (m_left[k] == 1);
      m_done[k] = 1'b0;
      m_spk[k] = (m_mode[k] == 2 && m_since[k] >= int'(Gap) && m_code[k] != 0 && !STOP && !ending)
                 ? NOTE_CLK[m_code[k] - 1] : 1'b0;
      if (STOP) begin
        m_mode[k] = 0; m_code[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (PLAY) begin m_mode[k] = 1; m_idx[k] = 0; end
      end else if (m_mode[k] == 1) begin
        if (beat) model_load(k, 0);
      end else begin
        m_since[k]++;
        if (ending) begin
          if (m_idx[k] < 15) model_load(k, m_idx[k] + 1);
          else if (k == 1) model_load(k, 0);
          else begin m_mode[k] = 0; m_code[k] = 0; m_done[k] = 1'b1; end
        end else if (beat) begin
          m_left[k]--;
        end
      end
    end
    m_qb_prev = QUARTER_BEAT;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    qb_cnt++;
    if (qb_cnt == Half) begin qb_cnt = 0; QUARTER_BEAT = ~QUARTER_BEAT; end
    NOTE_CLK = 8'($urandom);
  endtask

  task automatic go_idle();
    STOP = 1'b1; tick(); STOP = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({spk0, idx0, code0, busy0, done0, spk1, idx1, code1, busy1, done1} !== 22'd0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0",
               {spk0, idx0, code0, busy0, done0, spk1, idx1, code1, busy1, done1});
    end
    model_reset();
    RESET_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL reset_idle dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_start();
    bit found = 1'b0;
    bit prev;
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    checks++;
    if ({busy0, idx0, code0} !== 9'h100) begin
      failures++;
      $display("FAIL start_busy got=%h exp=100", {busy0, idx0, code0});
    end
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL start_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
      if (code0 == 4'd1) found = 1'b1;
    end
    checks++;
    if (!found || idx0 !== 4'd0) begin
      failures++;
      $display("FAIL start_load got_idx=%0d got_code=%0d exp_idx=0 exp_code=1", idx0, code0);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i < 5 && spk0 !== 1'b0) begin
        failures++;
        $display("FAIL start_gap_mute i=%0d got=%b exp=0", i, spk0);
      end else if (i >= 5 && spk0 !== prev) begin
        failures++;
        $display("FAIL start_follow i=%0d got=%b exp=%b", i, spk0, prev);
      end
      prev = NOTE_CLK[0];
      tick();
    end
  endtask

  task automatic test_full_play();
    int dur[16];
    int t_start = 0;
    int prev = 0;
    int done_cnt = 0;
    int loud14 = 0;
    bit started = 1'b0;
    bit seen = 1'b0;
    go_idle();
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    for (int i = 0; i < 16; i++) dur[i] = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      PLAY = ($urandom % 4 == 0);
      tick();
      PLAY = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL full_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
      if (!started && code0 == 4'd1) begin
        started = 1'b1; t_start = cyc; prev = 0;
      end else if (started && busy0 && int'(idx0) != prev) begin
        dur[prev] = cyc - t_start; t_start = cyc; prev = int'(idx0);
      end
      if (busy0 && idx0 == 4'd14 && spk0) loud14++;
      if (done0) begin
        done_cnt++; seen = 1'b1; dur[15] = cyc - t_start;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL full_timeout got=no_done exp=done");
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dur[i] != rom_beats[i] * Half) begin
        failures++;
        $display("FAIL full_duration idx=%0d got=%0d exp=%0d", i, dur[i], rom_beats[i] * Half);
      end
    end
    checks++;
    if (loud14 != 0) begin
      failures++;
      $display("FAIL full_rest_silent got=%0d exp=0", loud14);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done0) done_cnt++;
    end
    checks++;
    if (done_cnt != 1 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL full_done got_pulses=%0d got_busy=%b exp_pulses=1 exp_busy=0", done_cnt, busy0);
    end
  endtask

  task automatic test_loop();
    int done1_cnt = 0;
    bit seen = 1'b0;
    go_idle();
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL loop_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
      if (done1) done1_cnt++;
      if (done0) seen = 1'b1;
    end
    checks++;
    if (!seen || {idx1, code1, busy1, done1} !== 10'b0000_0001_1_0) begin
      failures++;
      $display("FAIL loop_wrap got=%h exp=006 seen=%b", {idx1, code1, busy1, done1}, seen);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done1) done1_cnt++;
    end
    checks++;
    if (done1_cnt != 0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL loop_no_done got_pulses=%0d got_busy=%b exp_pulses=0 exp_busy=1",
               done1_cnt, busy1);
    end
  endtask

  task automatic test_stop();
    bit found = 1'b0;
    go_idle();
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (idx0 == 4'd6) found = 1'b1;
    end
    for (int i = 0; i < 8; i++) tick();
    STOP = 1'b1; tick(); STOP = 1'b0;
    checks++;
    if (!found || {busy0, spk0, idx0, code0, done0} !== 11'b0_0_0110_0000_0) begin
      failures++;
      $display("FAIL stop_entry6 got=%h exp=0c0 found=%b", {busy0, spk0, idx0, code0, done0}, found);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL stop_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
    end
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    checks++;
    if ({busy0, idx0} !== 5'b1_0000) begin
      failures++;
      $display("FAIL stop_restart got=%h exp=10", {busy0, idx0});
    end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (code0 != 4'd0) found = 1'b1;
    end
    checks++;
    if ({idx0, code0} !== 8'h01) begin
      failures++;
      $display("FAIL stop_restart_entry got=%h exp=01", {idx0, code0});
    end
  endtask

  task automatic test_play_stop_idle();
    bit found = 1'b0;
    logic [3:0] idx_before;
    go_idle();
    PLAY = 1'b1; STOP = 1'b1; tick(); PLAY = 1'b0; STOP = 1'b0;
    checks++;
    if ({busy0, busy1} !== 2'b00) begin
      failures++;
      $display("FAIL play_stop_idle got=%b exp=00", {busy0, busy1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL idle_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
    end
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (code0 != 4'd0) found = 1'b1;
    end
    for (int i = 0; i < 5; i++) tick();
    idx_before = idx0;
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    checks++;
    if (!found || idx0 !== idx_before || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL play_while_busy got_idx=%0d got_busy=%b exp_idx=%0d exp_busy=1",
               idx0, busy0, idx_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      PLAY = ($urandom % 16 == 0);
      STOP = ($urandom % 128 == 0);
      tick();
      PLAY = 1'b0;
      STOP = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL random_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_sound();
    bit found = 1'b0;
    go_idle();
    PLAY = 1'b1; tick(); PLAY = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (idx0 == 4'd2) found = 1'b1;
    end
    for (int i = 0; i < 6; i++) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (!found || {spk0, busy0, code0, idx0, spk1, busy1, code1, idx1} !== 20'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0 found=%b",
               {spk0, busy0, code0, idx0, spk1, busy1, code1, idx1}, found);
    end
    model_reset();
    RESET_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL reset_needs_play dut%0d cyc=%0d got=%h exp=%h",
                   k, cyc, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_play();
    test_loop();
    test_stop();
    test_play_stop_idle();
    test_random();
    test_reset_mid_sound();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
